// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/bypass controller.
// Destination indices are stored at the widest supported width; narrower indices are zero-extended.
package pipe_pkg;

    localparam int RD_MAX_W   = 8;
    localparam int BYP_RF     = 0;
    localparam int RA_REG     = 31;
    localparam int STATUS_REG = 30;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                rwe;
        logic                load;
    } hz_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_hz_match.sv
// Per-operand priority finder: selects the youngest in-flight producer of one source register
// and flags when that producer is a load still sitting in the X stage.
module hz_match
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  hz_entry_t [DEPTH-1:0] entries,
    input  logic [REG_AW-1:0]     src,
    input  logic                  use_src,
    output logic [SEL_W-1:0]      sel,
    output logic                  is_load_hit
);

    logic [RD_MAX_W-1:0] src_ext;
    logic [DEPTH-1:0]    hit;

    assign src_ext = RD_MAX_W'(src);

    // r0 is never a producer, so a zero destination cannot hit.
    always_comb begin
        hit = '0;
        for (int j = 0; j < DEPTH; j++) begin
            hit[j] = use_src & entries[j].valid & entries[j].rwe &
                     (entries[j].rd != '0) & (entries[j].rd == src_ext);
        end
    end

    // Walk oldest to youngest so the youngest hit is the one left standing.
    always_comb begin
        sel = SEL_W'(BYP_RF);
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (hit[j]) begin
                sel = SEL_W'(j + 1);
            end
        end
    end

    assign is_load_hit = hit[0] & entries[0].load;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/bypass controller for the 5-stage pipeline: shadow destination pipe, D-stage stall,
// per-operand bypass selects and a single-outstanding mult/div busy counter.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int  REG_AW = 5,
    parameter int  DEPTH  = 3,
    parameter int  MD_LAT = 32,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_use_rs,
    input  logic              dec_use_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rwe,
    input  logic              dec_load,
    input  logic              dec_md,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  byp_sel_a,
    output logic [SEL_W-1:0]  byp_sel_b,
    output logic              md_busy,
    output logic              md_done
);

    localparam int CNT_W = $clog2(MD_LAT + 1);

    hz_entry_t [DEPTH-1:0] shadow;
    hz_entry_t             entry_in;
    logic [CNT_W-1:0]      md_cnt;
    logic [REG_AW-1:0]     md_rd;
    logic                  md_rwe;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             load_hit_a;
    logic             load_hit_b;
    logic             md_struct;
    logic             md_dep_a;
    logic             md_dep_b;
    logic             md_dep;
    logic             issue;
    logic             md_issue;

    hz_match #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_match_a (
        .entries     (shadow),
        .src         (dec_rs),
        .use_src     (dec_use_rs),
        .sel         (sel_a),
        .is_load_hit (load_hit_a)
    );

    hz_match #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW),
        .SEL_W  (SEL_W)
    ) u_match_b (
        .entries     (shadow),
        .src         (dec_rt),
        .use_src     (dec_use_rt),
        .sel         (sel_b),
        .is_load_hit (load_hit_b)
    );

    assign md_busy   = (md_cnt != '0);
    assign md_done   = (md_cnt == CNT_W'(1));
    assign md_struct = dec_md & md_busy;

    // The mult/div result is only architecturally visible once the counter drains.
    assign md_dep_a = dec_use_rs & (dec_rs == md_rd);
    assign md_dep_b = dec_use_rt & (dec_rt == md_rd);
    assign md_dep   = md_busy & md_rwe & (md_rd != '0) & (md_dep_a | md_dep_b);

    assign stall = dec_valid & ~flush & (load_hit_a | load_hit_b | md_struct | md_dep);

    // A load still in X has no result yet, so that operand falls back to the regfile.
    assign byp_sel_a = (dec_valid & ~load_hit_a) ? sel_a : SEL_W'(BYP_RF);
    assign byp_sel_b = (dec_valid & ~load_hit_b) ? sel_b : SEL_W'(BYP_RF);

    assign issue    = dec_valid & ~stall & ~flush;
    assign md_issue = issue & dec_md & ~md_busy;

    always_comb begin
        entry_in = '0;
        if (issue) begin
            entry_in.valid = 1'b1;
            entry_in.rd    = RD_MAX_W'(dec_rd);
            entry_in.rwe   = dec_rwe;
            entry_in.load  = dec_load;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            md_cnt <= '0;
            md_rd  <= '0;
            md_rwe <= 1'b0;
        end else begin
            shadow <= {shadow[DEPTH-2:0], entry_in};
            if (md_busy) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end else if (md_issue) begin
                md_cnt <= CNT_W'(MD_LAT);
                md_rd  <= dec_rd;
                md_rwe <= dec_rwe;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed pipeline scenarios plus random traffic
// compared against an in-flight instruction history model.
module tb_pipe_hazard_unit;

    localparam int DEPTH = 3;
    localparam int MDL   = 4;

    logic       clock;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic [4:0] dec_rd;
    logic       dec_rwe;
    logic       dec_load;
    logic       dec_md;
    logic       flush;
    logic       stall;
    logic [1:0] byp_sel_a;
    logic [1:0] byp_sel_b;
    logic       md_busy;
    logic       md_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       w;
        logic       ld;
        logic       md;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       w;
        logic       ld;
    } mi_t;

    // Model: the last DEPTH things that left D (index 0 = most recent), plus mult/div bookkeeping.
    mi_t        hist[$];
    int         md_left;
    logic [4:0] md_dst;
    logic       md_w;

    pipe_hazard_unit #(
        .REG_AW (5),
        .DEPTH  (DEPTH),
        .MD_LAT (MDL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_use_rs (dec_use_rs),
        .dec_use_rt (dec_use_rt),
        .dec_rd     (dec_rd),
        .dec_rwe    (dec_rwe),
        .dec_load   (dec_load),
        .dec_md     (dec_md),
        .flush      (flush),
        .stall      (stall),
        .byp_sel_a  (byp_sel_a),
        .byp_sel_b  (byp_sel_b),
        .md_busy    (md_busy),
        .md_done    (md_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t alu(int rd, int rs, int rt);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = 5'(rd); s.rs = 5'(rs); s.rt = 5'(rt);
        s.urs = 1'b1; s.urt = 1'b1; s.w = 1'b1;
        return s;
    endfunction

    function automatic stim_t lw(int rd, int base);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = 5'(rd); s.rs = 5'(base); s.urs = 1'b1;
        s.w = 1'b1; s.ld = 1'b1;
        return s;
    endfunction

    function automatic stim_t mdop(int rd, int w);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.md = 1'b1; s.rd = 5'(rd); s.w = w[0];
        return s;
    endfunction

    function automatic stim_t with_flush(stim_t s);
        stim_t r;
        r = s;
        r.fl = 1'b1;
        return r;
    endfunction

    function automatic stim_t inv(stim_t s);
        stim_t r;
        r = s;
        r.v = 1'b0;
        return r;
    endfunction

    function automatic stim_t nowr(stim_t s);
        stim_t r;
        r = s;
        r.w = 1'b0;
        return r;
    endfunction

    // Expected output vector {stall, sel_a, sel_b, busy, done}.
    function automatic logic [6:0] ev(int st, int sa, int sb, int bz, int dn);
        return {st[0], 2'(sa), 2'(sb), bz[0], dn[0]};
    endfunction

    function automatic logic [6:0] outv();
        return {stall, byp_sel_a, byp_sel_b, md_busy, md_done};
    endfunction

    function automatic int youngest(logic [4:0] src, logic use_src);
        if (!use_src || src == 5'd0) return -1;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].v && hist[k].w && hist[k].rd == src) return k;
        end
        return -1;
    endfunction

    // Returns {issues_this_cycle, expected output vector}.
    function automatic logic [7:0] model_eval();
        int   ya, yb, sa, sb;
        logic ld_a, ld_b, dep, st, iss;
        ya   = youngest(dec_rs, dec_use_rs);
        yb   = youngest(dec_rt, dec_use_rt);
        ld_a = (ya == 0) && hist[0].ld;
        ld_b = (yb == 0) && hist[0].ld;
        dep  = (md_left > 0) && md_w && (md_dst != 5'd0) &&
               ((dec_use_rs && dec_rs == md_dst) || (dec_use_rt && dec_rt == md_dst));
        st   = dec_valid && !flush && (ld_a || ld_b || (dec_md && md_left > 0) || dep);
        sa   = (!dec_valid || ya < 0 || ld_a) ? 0 : ya + 1;
        sb   = (!dec_valid || yb < 0 || ld_b) ? 0 : yb + 1;
        iss  = dec_valid && !st && !flush;
        return {iss, st, 2'(sa), 2'(sb), (md_left > 0), (md_left == 1)};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back('0);
        md_left = 0;
        md_dst  = '0;
        md_w    = 1'b0;
    endtask

    task automatic apply(stim_t s);
        @(posedge clock);
        dec_valid  = s.v;
        dec_rs     = s.rs;
        dec_rt     = s.rt;
        dec_use_rs = s.urs;
        dec_use_rt = s.urt;
        dec_rd     = s.rd;
        dec_rwe    = s.w;
        dec_load   = s.ld;
        dec_md     = s.md;
        flush      = s.fl;
        #1;
    endtask

    task automatic tick();
        logic [7:0] e;
        mi_t        m;
        e = model_eval();
        @(negedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            m = '0;
            if (e[7]) begin
                m.v = 1'b1; m.rd = dec_rd; m.w = dec_rwe; m.ld = dec_load;
            end
            hist.push_front(m);
            while (hist.size() > DEPTH) void'(hist.pop_back());
            if (md_left > 0) begin
                md_left--;
            end else if (e[7] && dec_md) begin
                md_left = MDL;
                md_dst  = dec_rd;
                md_w    = dec_rwe;
            end
        end
    endtask

    task automatic drain();
        repeat (6) begin
            apply(idle());
            tick();
        end
    endtask

    task automatic test_reset();
        model_reset();
        apply(alu(1, 2, 3));
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_alu: got %b expected %b", outv(), 7'd0);
        end
        apply(mdop(5, 1));
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_md: got %b expected %b", outv(), 7'd0);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", outv(), 7'd0);
        end
        tick();
        drain();
    endtask

    task automatic test_bypass();
        stim_t      st[5];
        logic [6:0] ex[5];
        st = '{alu(1, 2, 3), alu(4, 1, 5), alu(6, 1, 1), inv(alu(7, 4, 6)), alu(7, 4, 6)};
        ex = '{ev(0, 0, 0, 0, 0), ev(0, 1, 0, 0, 0), ev(0, 2, 2, 0, 0),
               ev(0, 0, 0, 0, 0), ev(0, 3, 2, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL bypass[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_load_use();
        stim_t      st[7];
        logic [6:0] ex[7];
        st = '{lw(7, 0), alu(8, 7, 7), alu(8, 7, 7), alu(9, 8, 7),
               lw(5, 0), alu(6, 1, 5), alu(6, 1, 5)};
        ex = '{ev(0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0), ev(0, 2, 2, 0, 0), ev(0, 1, 3, 0, 0),
               ev(0, 0, 0, 0, 0), ev(1, 0, 0, 0, 0), ev(0, 0, 2, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_r0();
        stim_t      st[7];
        logic [6:0] ex[7];
        st = '{alu(0, 1, 2), alu(3, 0, 0), lw(0, 0), alu(4, 0, 0),
               alu(5, 3, 0), nowr(alu(11, 0, 0)), alu(12, 11, 5)};
        ex = '{ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0),
               ev(0, 3, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 2, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL r0_nowrite[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_multicycle();
        stim_t      st[18];
        logic [6:0] ex[18];
        st = '{mdop(0, 0), mdop(0, 0), mdop(0, 0), mdop(0, 0), mdop(0, 0), mdop(0, 0),
               idle(), idle(), idle(), idle(), idle(),
               mdop(9, 1), alu(10, 9, 0), alu(10, 9, 0), alu(10, 9, 0), alu(10, 9, 0),
               alu(10, 9, 0), idle()};
        ex = '{ev(0, 0, 0, 0, 0), ev(1, 0, 0, 1, 0), ev(1, 0, 0, 1, 0), ev(1, 0, 0, 1, 0),
               ev(1, 0, 0, 1, 1), ev(0, 0, 0, 0, 0),
               ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 1),
               ev(0, 0, 0, 0, 0),
               ev(0, 0, 0, 0, 0), ev(1, 1, 0, 1, 0), ev(1, 2, 0, 1, 0), ev(1, 3, 0, 1, 0),
               ev(1, 0, 0, 1, 1), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0)};
        for (int i = 0; i < 18; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL multicycle[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_flush();
        stim_t      st[11];
        logic [6:0] ex[11];
        st = '{lw(7, 0), with_flush(alu(8, 7, 7)), alu(9, 8, 8), alu(10, 7, 9),
               mdop(0, 0), with_flush(idle()), with_flush(mdop(0, 0)), idle(), idle(),
               with_flush(mdop(0, 0)), idle()};
        ex = '{ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 3, 1, 0, 0),
               ev(0, 0, 0, 0, 0), ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 0),
               ev(0, 0, 0, 1, 1), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0)};
        for (int i = 0; i < 11; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        stim_t      s;
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            s     = '0;
            s.v   = ($urandom_range(0, 9) < 8);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.urs = ($urandom_range(0, 3) != 0);
            s.urt = ($urandom_range(0, 3) != 0);
            s.rd  = 5'($urandom_range(0, 3));
            s.w   = ($urandom_range(0, 4) != 0);
            s.ld  = s.w && ($urandom_range(0, 3) == 0);
            s.md  = ($urandom_range(0, 14) == 0);
            s.fl  = ($urandom_range(0, 9) == 0);
            apply(s);
            e = model_eval();
            n_checks++;
            if (outv() !== e[6:0]) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, outv(), e[6:0]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        stim_t      st[3];
        logic [6:0] ex[3];
        st = '{mdop(0, 0), alu(1, 2, 3), alu(2, 3, 4)};
        ex = '{ev(0, 0, 0, 0, 0), ev(0, 0, 0, 1, 0), ev(0, 0, 0, 1, 0)};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            n_checks++;
            if (outv() !== ex[i]) begin
                n_fail++;
                $display("FAIL reset_mid_fill[%0d]: got %b expected %b", i, outv(), ex[i]);
            end
            tick();
        end
        apply(alu(3, 2, 1));
        n_checks++;
        if (outv() !== ev(0, 1, 2, 1, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_before: got %b expected %b", outv(), ev(0, 1, 2, 1, 0));
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected %b", outv(), 7'd0);
        end
        @(negedge clock);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got %b expected %b", outv(), 7'd0);
        end
        tick();
        apply(idle());
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %b expected %b", outv(), 7'd0);
        end
        tick();
        apply(mdop(0, 0));
        n_checks++;
        if (outv() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_reissue: got %b expected %b", outv(), 7'd0);
        end
        tick();
        apply(idle());
        n_checks++;
        if (outv() !== ev(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b expected %b", outv(), ev(0, 0, 0, 1, 0));
        end
        tick();
        drain();
    endtask

    initial begin
        reset      = 1'b0;
        dec_valid  = 1'b0;
        dec_rs     = '0;
        dec_rt     = '0;
        dec_use_rs = 1'b0;
        dec_use_rt = 1'b0;
        dec_rd     = '0;
        dec_rwe    = 1'b0;
        dec_load   = 1'b0;
        dec_md     = 1'b0;
        flush      = 1'b0;
        test_reset();
        test_bypass();
        test_load_use();
        test_r0();
        test_multicycle();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
